fault_rng_arbiter: RTL and testbench



---
 rtl/fault_rng_pkg.sv | 24 ++
 rtl/fault_rng_arbiter_if.sv | 28 ++
 rtl/fault_rng_lfsr.sv | 28 ++
 rtl/fault_rng_arbiter.sv | 143 ++++++++++++++
 tb/tb_fault_rng_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/fault_rng_pkg.sv
// Shared constants, FSM state type and LFSR step function for the fault RNG arbiter.
package fault_rng_pkg;

  localparam int unsigned LFSR_W = 12;

  localparam int unsigned TAP_A = 11;
  localparam int unsigned TAP_B = 5;
  localparam int unsigned TAP_C = 3;
  localparam int unsigned TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 12'hAAA;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    FLUSH,
    DONE
  } fault_rng_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

endpackage

// File: rtl/fault_rng_arbiter_if.sv
// Step-scheduler / fault-gate bus of the fault RNG arbiter; master = scheduler side.
interface fault_rng_arbiter_if
  import fault_rng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic                       step_start;
  logic [NUM_REQ-1:0]         req;
  logic [LFSR_W*NUM_REQ-1:0]  thresh;
  logic [NUM_REQ-1:0]         grant;
  logic                       result;
  logic                       busy;
  logic                       logic_reset;
  logic                       step_done;
  logic [15:0]                hit_count;

  modport master (
    output step_start, req, thresh,
    input  grant, result, busy, logic_reset, step_done, hit_count
  );

  modport slave (
    input  step_start, req, thresh,
    output grant, result, busy, logic_reset, step_done, hit_count
  );

endinterface

// File: rtl/fault_rng_lfsr.sv
// 12-bit Fibonacci LFSR shared by all requesters; advances only when adv_i is high.
module fault_rng_lfsr
  import fault_rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  // An all-zero state would lock up the register.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED_EFF;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/fault_rng_arbiter.sv
// Round-robin sharing of one LFSR among NUM_REQ faulty gates per wiring step.
// Optional hit counter enabled by defining FAULT_RNG_STATS_EN.
module fault_rng_arbiter
  import fault_rng_pkg::*;
#(
  parameter int unsigned       NUM_REQ   = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                reset_n,
  fault_rng_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  fault_rng_state_t   state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               result_q, result_d;
  logic               busy_q, busy_d;
  logic               lreset_q, lreset_d;
  logic               done_q, done_d;

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  sel_thresh;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_found;
  logic               cmp;
  logic               adv;
  int unsigned        cand;

  fault_rng_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .adv_i   (adv),
    .lfsr_o  (lfsr)
  );

  // First pending index at or after rr_q, scanning with wrap-around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(cand);
      end
    end
  end

  assign sel_thresh = bus.thresh[32'(sel_idx)*LFSR_W +: LFSR_W];
  assign cmp        = (lfsr < sel_thresh);
  assign adv        = (state_q == SERVE) && sel_found;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    grant_d   = '0;
    result_d  = 1'b0;
    busy_d    = busy_q;
    lreset_d  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.step_start) begin
          pending_d = bus.req;
          busy_d    = 1'b1;
          state_d   = (bus.req == '0) ? FLUSH : SERVE;
        end
      end
      SERVE: begin
        if (sel_found) begin
          grant_d            = NUM_REQ'(1) << sel_idx;
          result_d           = cmp;
          pending_d[sel_idx] = 1'b0;
          rr_d               = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + PTR_W'(1);
        end
        if (pending_d == '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        lreset_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      result_q  <= 1'b0;
      busy_q    <= 1'b0;
      lreset_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      lreset_q  <= lreset_d;
      done_q    <= done_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.logic_reset = lreset_q;
  assign bus.step_done   = done_q;

`ifdef FAULT_RNG_STATS_EN
  logic [15:0] hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= '0;
    end else if (adv && cmp && (hit_q != '1)) begin
      hit_q <= hit_q + 16'd1;
    end
  end

  assign bus.hit_count = hit_q;
`else
  assign bus.hit_count = '0;
`endif

endmodule

// File: tb/tb_fault_rng_arbiter.sv
// Directed self-checking bench for fault_rng_arbiter (NUM_REQ=4, seed 12'hAAA).
module tb_fault_rng_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   exp_hit;

  fault_rng_arbiter_if #(.NUM_REQ(4)) bus ();

  fault_rng_arbiter #(
    .NUM_REQ   (4),
    .LFSR_SEED (12'hAAA)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] th4(input logic [11:0] t3, input logic [11:0] t2,
                                      input logic [11:0] t1, input logic [11:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},  32'(bus.grant), 32'h0);
    check({tag, "_result"}, 32'(bus.result), 32'h0);
    check({tag, "_busy"},   32'(bus.busy), 32'h0);
    check({tag, "_lreset"}, 32'(bus.logic_reset), 32'h0);
    check({tag, "_done"},   32'(bus.step_done), 32'h0);
    check({tag, "_hits"},   32'(bus.hit_count), 32'(exp_hit));
  endtask

  // Called at a negedge; gs holds the expected grant per served slot (nibble j), rs the results.
  task automatic run_step(input string tag, input logic [3:0] rq, input logic [47:0] th,
                          input int k, input logic [15:0] gs, input logic [3:0] rs,
                          input bit intrude);
    bus.req        = rq;
    bus.thresh     = th;
    bus.step_start = 1'b1;
    @(negedge clk);
    bus.step_start = 1'b0;
    bus.req        = ~rq;
    check({tag, "_busy_e0"},  32'(bus.busy), 32'h1);
    check({tag, "_grant_e0"}, 32'(bus.grant), 32'h0);
    for (int j = 0; j < k; j++) begin
      if (intrude && j == 0) begin
        bus.step_start = 1'b1;
        bus.req        = 4'hF;
      end
      @(negedge clk);
      bus.step_start = 1'b0;
      check($sformatf("%s_grant%0d", tag, j),  32'(bus.grant), 32'(gs[4*j +: 4]));
      check($sformatf("%s_result%0d", tag, j), 32'(bus.result), 32'(rs[j]));
      check($sformatf("%s_lr%0d", tag, j),     32'(bus.logic_reset), 32'h0);
`ifdef FAULT_RNG_STATS_EN
      if (rs[j]) exp_hit++;
`endif
    end
    @(negedge clk);
    check({tag, "_lreset"},    32'(bus.logic_reset), 32'h1);
    check({tag, "_lr_grant"},  32'(bus.grant), 32'h0);
    check({tag, "_lr_done"},   32'(bus.step_done), 32'h0);
    check({tag, "_lr_busy"},   32'(bus.busy), 32'h1);
    @(negedge clk);
    check({tag, "_done"},      32'(bus.step_done), 32'h1);
    check({tag, "_done_lr"},   32'(bus.logic_reset), 32'h0);
    @(negedge clk);
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    exp_hit        = 0;
    reset_n        = 1'b0;
    bus.step_start = 1'b0;
    bus.req        = '0;
    bus.thresh     = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Empty step must not touch the LFSR: next results depend on AAA then 555.
    run_step("empty", 4'b0000, th4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 0, 16'h0, 4'b0000, 1'b0);
    run_step("basic", 4'b0101, th4(12'h000, 12'h556, 12'h000, 12'hAAB), 2, 16'h0041, 4'b0011, 1'b0);
    // rr_ptr is now 3: index 3 first, then wrap to 0.
    run_step("rrwrap", 4'b1001, th4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 2, 16'h0018, 4'b0011, 1'b0);

    reset_n = 1'b0;
    exp_hit = 0;
    #1 check_idle_outputs("rst2");
    @(negedge clk);
    reset_n = 1'b1;
    run_step("step1", 4'b1001, th4(12'h800, 12'h800, 12'h800, 12'h800), 2, 16'h0081, 4'b0010, 1'b0);
    run_step("step2", 4'b1001, th4(12'h800, 12'h800, 12'h800, 12'h800), 2, 16'h0081, 4'b0010, 1'b0);
    run_step("zero",  4'b1111, th4(12'h000, 12'h000, 12'h000, 12'h000), 4, 16'h8421, 4'b0000, 1'b0);

    bus.req        = 4'b1111;
    bus.thresh     = th4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    bus.step_start = 1'b1;
    @(negedge clk);
    bus.step_start = 1'b0;
    @(negedge clk);
    check("mid_grant0", 32'(bus.grant), 32'h1);
    @(negedge clk);
    check("mid_grant1", 32'(bus.grant), 32'h2);
    reset_n = 1'b0;
    exp_hit = 0;
    #1 check_idle_outputs("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    // Results 0,1,0,1 follow from LFSR AAA,555,AAB,556 against 800.
    run_step("postrst", 4'b1111, th4(12'h800, 12'h800, 12'h800, 12'h800), 4, 16'h8421, 4'b1010, 1'b0);

    // LFSR now AAC then 559; extra step_start during the step must be ignored.
    run_step("intrude", 4'b0110, th4(12'h800, 12'h800, 12'h800, 12'h800), 2, 16'h0042, 4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("intrude_quiet%0d", c), {29'h0, bus.step_done, bus.busy, bus.logic_reset}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
